// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the D/M stage control and the PC generator.
// Carries the D-stage jump operands, exception/ERET controls and fetch results.
// The master drives redirect controls; the slave returns PC, prediction and error status.
interface pc_gen_if #(
  parameter int CNT_W = 16
);
  logic              stall;
  logic [31:0]       pc_D;
  logic [25:0]       imm26;
  logic [31:0]       rd1;
  logic              cmp;
  logic [2:0]        jump_op;
  logic              rs_is_ra;
  logic              exc_req;
  logic              eret;
  logic [31:0]       epc;
  logic [31:0]       pc_F;
  logic [31:0]       pc4_F;
  logic [31:0]       npc;
  logic              fetch_err;
  logic              ras_miss;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    output stall, pc_D, imm26, rd1, cmp, jump_op, rs_is_ra, exc_req, eret, epc,
    input  pc_F, pc4_F, npc, fetch_err, ras_miss, miss_cnt
  );

  modport slave (
    input  stall, pc_D, imm26, rd1, cmp, jump_op, rs_is_ra, exc_req, eret, epc,
    output pc_F, pc4_F, npc, fetch_err, ras_miss, miss_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with a return-address stack for JR prediction.
// Latency: npc is combinational; pc_F follows npc one cycle later; ras_miss is registered (+1 cycle).
// Backpressure: stall holds PC and RAS; exc_req/eret redirect even while stalled.
module pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096,
  parameter int          RAS_DEPTH  = 8,
  parameter int          CNT_W      = 16
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);

  localparam int TP_W  = $clog2(RAS_DEPTH);
  localparam int OCC_W = $clog2(RAS_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(RAS_DEPTH);
  localparam logic [31:0]      IMEM_LAST = IMEM_BASE + 32'(4 * IMEM_WORDS) - 32'd4;

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_J      = 3'd2;
  localparam logic [2:0] OP_JAL    = 3'd3;
  localparam logic [2:0] OP_JR     = 3'd4;
  localparam logic [2:0] OP_JALR   = 3'd5;

  // Architectural state
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ras_q [RAS_DEPTH];
  logic [31:0]      ras_d [RAS_DEPTH];
  logic [TP_W-1:0]  tp_q, tp_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ras_miss_q, ras_miss_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Redirect candidates
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] ret_addr;
  logic [31:0] npc;

  // RAS control
  logic            advance;
  logic            is_call;
  logic            is_ret;
  logic [TP_W-1:0] top_idx;
  logic [31:0]     ras_top;

  // Candidate next-PC values; the branch target counts from the delay slot.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    br_target = bus.pc_D + 32'd4 + {{14{bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
    j_target  = {bus.pc_D[31:28], bus.imm26, 2'b00};
    ret_addr  = bus.pc_D + 32'd8;
  end

  // Next-PC select: exception, then ERET, then the D-stage jump type.
  always_comb begin
    npc = pc_plus4;
    if (bus.exc_req) begin
      npc = EXC_VEC;
    end else if (bus.eret) begin
      npc = bus.epc;
    end else begin
      unique case (bus.jump_op)
        OP_BRANCH:       npc = bus.cmp ? br_target : pc_plus4;
        OP_J, OP_JAL:    npc = j_target;
        OP_JR, OP_JALR:  npc = bus.rd1;
        default:         npc = pc_plus4;
      endcase
    end
  end

  // PC load: exception/ERET redirects override the hazard stall.
  always_comb begin
    pc_d = pc_q;
    if (bus.exc_req || bus.eret || !bus.stall) begin
      pc_d = npc;
    end
  end

  // RAS update and prediction check; only steps on an unstalled, non-trapping cycle.
  always_comb begin
    advance    = !bus.stall && !bus.exc_req && !bus.eret;
    is_call    = (bus.jump_op == OP_JAL) || (bus.jump_op == OP_JALR);
    is_ret     = ((bus.jump_op == OP_JR) || (bus.jump_op == OP_JALR)) && bus.rs_is_ra;
    top_idx    = tp_q - TP_W'(1);
    ras_top    = ras_q[top_idx];
    ras_d      = ras_q;
    tp_d       = tp_q;
    occ_d      = occ_q;
    ras_miss_d = 1'b0;
    if (advance) begin
      // An empty stack offers no prediction, so it can never mispredict.
      if (is_ret && (occ_q != '0) && (ras_top != bus.rd1)) begin
        ras_miss_d = 1'b1;
      end
      if (is_call && is_ret && (occ_q != '0)) begin
        // JALR through ra: pop then push collapses to replacing the top.
        ras_d[top_idx] = ret_addr;
      end else if (is_call) begin
        // When full, slot tp holds the oldest entry and is overwritten.
        ras_d[tp_q] = ret_addr;
        tp_d        = tp_q + TP_W'(1);
        if (occ_q != OCC_FULL) begin
          occ_d = occ_q + OCC_W'(1);
        end
      end else if (is_ret && (occ_q != '0)) begin
        tp_d  = top_idx;
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  // Mispredict counter moves on the same edge as the ras_miss pulse and saturates.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (ras_miss_d && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tp_q       <= '0;
      occ_q      <= '0;
      ras_miss_q <= 1'b0;
      miss_cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      tp_q       <= tp_d;
      occ_q      <= occ_d;
      ras_miss_q <= ras_miss_d;
      miss_cnt_q <= miss_cnt_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign bus.pc_F      = pc_q;
  assign bus.pc4_F     = pc_plus4;
  assign bus.npc       = npc;
  assign bus.ras_miss  = ras_miss_q;
  assign bus.miss_cnt  = miss_cnt_q;
  assign bus.fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || (pc_q > IMEM_LAST);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen built with a 4-bit mispredict counter.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
// Every expected value below is hand-computed from the fetch-address rules.
module tb_pc_gen;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_gen_if #(.CNT_W(4)) bus ();

  pc_gen #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall    = 1'b0;
    bus.pc_D     = 32'h0;
    bus.imm26    = 26'h0;
    bus.rd1      = 32'h0;
    bus.cmp      = 1'b0;
    bus.jump_op  = 3'd0;
    bus.rs_is_ra = 1'b0;
    bus.exc_req  = 1'b0;
    bus.eret     = 1'b0;
    bus.epc      = 32'h0;
  endtask

  // One JAL at pc_D (target 0x3040) followed by a JR through ra with the given rd1.
  task automatic call_ret(input logic [31:0] pcd, input logic [31:0] r1);
    idle();
    bus.jump_op = 3'd3; bus.pc_D = pcd; bus.imm26 = 26'h0000C10;
    tick();
    idle();
    bus.jump_op = 3'd4; bus.rs_is_ra = 1'b1; bus.rd1 = r1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_pc", bus.pc_F, 32'h3000);
    chk("rst_pc4", bus.pc4_F, 32'h3004);
    chk("rst_miss", {31'd0, bus.ras_miss}, 32'd0);
    chk("rst_cnt", {28'd0, bus.miss_cnt}, 32'd0);
    chk("rst_ferr", {31'd0, bus.fetch_err}, 32'd0);

    // Sequential fetch
    reset = 1'b0;
    tick(); chk("seq1", bus.pc_F, 32'h3004);
    tick(); chk("seq2", bus.pc_F, 32'h3008);
    tick(); chk("seq3", bus.pc_F, 32'h300C);
    chk("seq_ferr", {31'd0, bus.fetch_err}, 32'd0);

    // Backward branch taken / not taken
    bus.jump_op = 3'd1; bus.pc_D = 32'h3010; bus.imm26 = 26'h000FFFE; bus.cmp = 1'b1;
    #1 chk("br_npc", bus.npc, 32'h300C);
    tick(); chk("br_taken", bus.pc_F, 32'h300C);
    bus.cmp = 1'b0;
    #1 chk("br_nt_npc", bus.npc, 32'h3010);
    tick(); chk("br_not", bus.pc_F, 32'h3010);

    // JAL then correct JR prediction
    idle();
    bus.jump_op = 3'd3; bus.pc_D = 32'h3000; bus.imm26 = 26'h0000C10;
    #1 chk("jal_npc", bus.npc, 32'h3040);
    tick(); chk("jal_pc", bus.pc_F, 32'h3040);
    idle();
    bus.jump_op = 3'd4; bus.rs_is_ra = 1'b1; bus.rd1 = 32'h3008;
    tick();
    chk("jr_pc", bus.pc_F, 32'h3008);
    chk("jr_hit_miss", {31'd0, bus.ras_miss}, 32'd0);

    // JAL then wrong JR prediction
    call_ret(32'h3000, 32'h3100);
    chk("jr_wrong_pc", bus.pc_F, 32'h3100);
    chk("jr_wrong_miss", {31'd0, bus.ras_miss}, 32'd1);
    chk("jr_wrong_cnt", {28'd0, bus.miss_cnt}, 32'd1);
    idle();
    tick();
    chk("miss_pulse_end", {31'd0, bus.ras_miss}, 32'd0);
    chk("miss_cnt_hold", {28'd0, bus.miss_cnt}, 32'd1);
    chk("seq_after", bus.pc_F, 32'h3104);

    // Nine calls overflow the 8-deep stack; eight returns predict 9th..2nd
    for (int k = 1; k <= 9; k++) begin
      idle();
      bus.jump_op = 3'd3; bus.pc_D = 32'h3000 + 32'(k * 16); bus.imm26 = 26'h0000C10;
      tick();
    end
    for (int k = 9; k >= 2; k--) begin
      idle();
      bus.jump_op = 3'd4; bus.rs_is_ra = 1'b1; bus.rd1 = 32'h3008 + 32'(k * 16);
      tick();
      chk($sformatf("ras_pop%0d", k), {31'd0, bus.ras_miss}, 32'd0);
    end
    idle();
    bus.jump_op = 3'd4; bus.rs_is_ra = 1'b1; bus.rd1 = 32'h3300;
    tick();
    chk("ras_empty_pc", bus.pc_F, 32'h3300);
    chk("ras_empty_miss", {31'd0, bus.ras_miss}, 32'd0);
    chk("ras_empty_cnt", {28'd0, bus.miss_cnt}, 32'd1);

    // Stall with J pending holds the PC; traps override the stall
    idle();
    bus.stall = 1'b1; bus.jump_op = 3'd2; bus.imm26 = 26'h0000C80;
    tick(); chk("stall1", bus.pc_F, 32'h3300);
    tick(); chk("stall2", bus.pc_F, 32'h3300);
    bus.exc_req = 1'b1;
    #1 chk("exc_npc", bus.npc, 32'h4180);
    tick(); chk("exc_pc", bus.pc_F, 32'h4180);
    bus.exc_req = 1'b0; bus.eret = 1'b1; bus.epc = 32'h3050;
    tick(); chk("eret_pc", bus.pc_F, 32'h3050);
    bus.exc_req = 1'b1; bus.jump_op = 3'd3; bus.pc_D = 32'h3000;
    tick(); chk("exc_eret_pc", bus.pc_F, 32'h4180);
    idle();
    bus.jump_op = 3'd2; bus.imm26 = 26'h0000C80;
    tick(); chk("stall_rel_j", bus.pc_F, 32'h3200);
    // The JAL under exc_req must not have pushed: this return finds the stack empty
    idle();
    bus.jump_op = 3'd4; bus.rs_is_ra = 1'b1; bus.rd1 = 32'h3300;
    tick(); chk("exc_no_push", {31'd0, bus.ras_miss}, 32'd0);

    // JALR through ra replaces the top with pc_D+8
    idle();
    bus.jump_op = 3'd3; bus.pc_D = 32'h3000; bus.imm26 = 26'h0000C10;
    tick();
    idle();
    bus.jump_op = 3'd5; bus.rs_is_ra = 1'b1; bus.rd1 = 32'h3008; bus.pc_D = 32'h3020;
    tick();
    chk("jalr_pc", bus.pc_F, 32'h3008);
    chk("jalr_hit", {31'd0, bus.ras_miss}, 32'd0);
    idle();
    bus.jump_op = 3'd4; bus.rs_is_ra = 1'b1; bus.rd1 = 32'h3028;
    tick(); chk("jalr_top", {31'd0, bus.ras_miss}, 32'd0);
    idle();
    bus.jump_op = 3'd4; bus.rs_is_ra = 1'b1; bus.rd1 = 32'h3400;
    tick(); chk("jalr_depth", {31'd0, bus.ras_miss}, 32'd0);

    // Fetch address range and alignment
    idle(); bus.jump_op = 3'd4; bus.rd1 = 32'h3002;
    tick(); chk("ferr_misalign", {31'd0, bus.fetch_err}, 32'd1);
    bus.rd1 = 32'h7000;
    tick(); chk("ferr_high", {31'd0, bus.fetch_err}, 32'd1);
    bus.rd1 = 32'h6FFC;
    tick(); chk("ferr_last_ok", {31'd0, bus.fetch_err}, 32'd0);
    bus.rd1 = 32'h2FFC;
    tick(); chk("ferr_low", {31'd0, bus.fetch_err}, 32'd1);

    // Sixteen more mispredicts (17 in total) saturate the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      call_ret(32'h3000, 32'h3100);
      chk($sformatf("sat_miss%0d", k), {31'd0, bus.ras_miss}, 32'd1);
    end
    chk("sat_cnt", {28'd0, bus.miss_cnt}, 32'd15);
    idle();
    tick();
    chk("sat_cnt_hold", {28'd0, bus.miss_cnt}, 32'd15);

    // Reset mid-run overrides a pending jump
    bus.jump_op = 3'd2; bus.imm26 = 26'h0000C80;
    reset = 1'b1;
    tick();
    chk("rst2_pc", bus.pc_F, 32'h3000);
    chk("rst2_cnt", {28'd0, bus.miss_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
